ram_loader: RTL

- Byte-stream program loader sitting directly upstream of the tinycpu 4096x16 RAM.
- Receives a framed image over an 8-bit valid/ready stream, assembles big-endian 16-bit words, and drives the RAM write port (load/addr/d) sequentially.
- While idle, it passes the CPU's RAM request straight through, so the RAM sees a single master at all times.
- Asserts cpu_hold while loading, so the CPU stalls until the image is in memory.

---
 rtl/ram_loader_pkg.sv | 26 ++
 rtl/ram_loader_if.sv | 31 +++
 rtl/ram_port_mux.sv | 35 +++
 rtl/ram_loader.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the RAM program loader.
// Optional checksum trailer is enabled by defining RAM_LOADER_CKSUM_EN.
package ram_loader_pkg;

    localparam int BYTE_W    = 8;
    localparam int MAX_WORDS = 4096;

    typedef enum logic [3:0] {
        IDLE,
        A_LO,
        C_HI,
        C_LO,
        D_HI,
        D_LO,
        WRITE,
        CK,
        FINISH,
        ERROR
    } state_t;

    // The byte stream is stalled only in the single-cycle internal states.
    function automatic logic state_accepts(input state_t s);
        return !(s == WRITE || s == FINISH || s == ERROR);
    endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Loader bus bundle: byte stream in, CPU RAM request in, RAM port and status out.
interface ram_loader_if #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 16
);
    import ram_loader_pkg::*;

    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_ready;
    logic              cpu_load;
    logic [AWIDTH-1:0] cpu_addr;
    logic [DWIDTH-1:0] cpu_d;
    logic              ram_load;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_d;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport slave (
        input  rx_valid, rx_data, cpu_load, cpu_addr, cpu_d,
        output rx_ready, ram_load, ram_addr, ram_d, cpu_hold, done, err
    );

    modport master (
        output rx_valid, rx_data, cpu_load, cpu_addr, cpu_d,
        input  rx_ready, ram_load, ram_addr, ram_d, cpu_hold, done, err
    );

endinterface

// File: rtl/ram_port_mux.sv
// Combinational 2:1 selection of the RAM write port between the CPU and the loader.
module ram_port_mux #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 16
) (
    input  logic              sel,
    input  logic              cpu_load,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_d,
    input  logic              ldr_load,
    input  logic [AWIDTH-1:0] ldr_addr,
    input  logic [DWIDTH-1:0] ldr_d,
    output logic              ram_load,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_d
);
    localparam int W = 1 + AWIDTH + DWIDTH;

    logic [W-1:0] cpu_bus;
    logic [W-1:0] ldr_bus;
    logic [W-1:0] ram_bus;

    assign cpu_bus = {cpu_load, cpu_addr, cpu_d};
    assign ldr_bus = {ldr_load, ldr_addr, ldr_d};

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_sel
            assign ram_bus[gi] = sel ? ldr_bus[gi] : cpu_bus[gi];
        end
    endgenerate

    assign {ram_load, ram_addr, ram_d} = ram_bus;

endmodule

// File: rtl/ram_loader.sv
// Framed byte-stream loader driving the RAM write port; CPU passes through when idle.
// Optional trailing checksum byte enabled by defining RAM_LOADER_CKSUM_EN.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    ram_loader_if.slave  bus
);

    state_t state_reg, state_next;
    // Held at 16 bits; only the low AWIDTH bits reach the RAM, so increments wrap.
    logic [15:0]       addr_reg, addr_next;
    logic [15:0]       remaining_reg, remaining_next;
    logic [BYTE_W-1:0] cnt_hi_reg, cnt_hi_next;
    logic [BYTE_W-1:0] hi_reg, hi_next;
    logic [BYTE_W-1:0] lo_reg, lo_next;
    logic              err_reg, err_next;

    logic        rx_ready;
    logic        accept;
    logic        ldr_load;
    logic [15:0] cnt_word;
    state_t      frame_end;

    assign rx_ready = state_accepts(state_reg);
    assign accept   = bus.rx_valid && rx_ready;
    assign cnt_word = {cnt_hi_reg, bus.rx_data};

`ifdef RAM_LOADER_CKSUM_EN
    logic [BYTE_W-1:0] sum_reg, sum_next;
    logic              ck_ok;

    assign frame_end = CK;
    assign ck_ok     = (sum_reg + bus.rx_data) == 8'h00;

    always_comb begin
        sum_next = sum_reg;
        if (accept) begin
            sum_next = (state_reg == IDLE) ? bus.rx_data : sum_reg + bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_reg <= '0;
        end else begin
            sum_reg <= sum_next;
        end
    end
`else
    assign frame_end = FINISH;
`endif

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        cnt_hi_next    = cnt_hi_reg;
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        err_next       = err_reg;
        ldr_load       = 1'b0;
        case (state_reg)
            IDLE: if (accept) begin
                addr_next  = {bus.rx_data, 8'h00};
                err_next   = 1'b0;
                state_next = A_LO;
            end
            A_LO: if (accept) begin
                addr_next[7:0] = bus.rx_data;
                state_next     = C_HI;
            end
            C_HI: if (accept) begin
                cnt_hi_next = bus.rx_data;
                state_next  = C_LO;
            end
            C_LO: if (accept) begin
                remaining_next = cnt_word;
                if (cnt_word == 16'd0) begin
                    state_next = frame_end;
                end else if (cnt_word > 16'(MAX_WORDS)) begin
                    err_next   = 1'b1;
                    state_next = ERROR;
                end else begin
                    state_next = D_HI;
                end
            end
            D_HI: if (accept) begin
                hi_next    = bus.rx_data;
                state_next = D_LO;
            end
            D_LO: if (accept) begin
                lo_next    = bus.rx_data;
                state_next = WRITE;
            end
            WRITE: begin
                ldr_load       = 1'b1;
                addr_next      = addr_reg + 16'd1;
                remaining_next = remaining_reg - 16'd1;
                state_next     = (remaining_reg == 16'd1) ? frame_end : D_HI;
            end
`ifdef RAM_LOADER_CKSUM_EN
            CK: if (accept) begin
                if (ck_ok) begin
                    state_next = FINISH;
                end else begin
                    err_next   = 1'b1;
                    state_next = ERROR;
                end
            end
`endif
            FINISH:  state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            cnt_hi_reg    <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            cnt_hi_reg    <= cnt_hi_next;
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            err_reg       <= err_next;
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.cpu_hold = (state_reg != IDLE);
    assign bus.done     = (state_reg == FINISH);
    assign bus.err      = err_reg;

    ram_port_mux #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_mux (
        .sel      (bus.cpu_hold),
        .cpu_load (bus.cpu_load),
        .cpu_addr (bus.cpu_addr),
        .cpu_d    (bus.cpu_d),
        .ldr_load (ldr_load),
        .ldr_addr (addr_reg[AWIDTH-1:0]),
        .ldr_d    (DWIDTH'({hi_reg, lo_reg})),
        .ram_load (bus.ram_load),
        .ram_addr (bus.ram_addr),
        .ram_d    (bus.ram_d)
    );

endmodule
